udt_tx_arbiter: RTL and testbench

UDT_TX_ARBITER -- requirements
Module: udt_tx_arbiter

---
 rtl/udt_pkg.sv | 13 +
 rtl/udt_rr_pick.sv | 28 ++
 rtl/udt_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_udt_tx_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/udt_pkg.sv
// Shared UDT tx arbiter definitions: socket state codes and
// the FSM encoding.
package udt_pkg;

  localparam logic [31:0] UDT_CONNECT = 32'h0000_0001;
  localparam logic [31:0] UDT_CLOSE   = 32'h0000_0002;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/udt_rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr.
// Ports: req (N), ptr (PW) -> gnt (N, one-hot or zero).
module udt_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udt_tx_arbiter.sv
// Packet arbiter: N_REQ UDT-enabled AXIS streams onto one tx port.
// Ports: core_clk/core_rst, s_t*_i/s_tready_o per requester,
// m_t* shared tx, udt_state_i/state_sel_i/state_valid_i enable
// updates, grant_o one-hot grant, timeout_o stall-release pulse.
// Stall release is built only with UDT_TX_ARB_TIMEOUT_EN.
module udt_tx_arbiter
  import udt_pkg::*;
#(
  parameter int          N_REQ   = 4,
  parameter int          DATA_W  = 32,
  parameter logic [31:0] CONNECT = UDT_CONNECT,
  parameter logic [31:0] CLOSE   = UDT_CLOSE,
  parameter int          TIMEOUT = 1024
) (
  input  logic                    core_clk,
  input  logic                    core_rst,
  input  logic [N_REQ-1:0]        s_tvalid_i,
  input  logic [N_REQ*DATA_W-1:0] s_tdata_i,
  input  logic [N_REQ-1:0]        s_tlast_i,
  output logic [N_REQ-1:0]        s_tready_o,
  output logic                    m_tvalid_o,
  output logic [DATA_W-1:0]       m_tdata_o,
  output logic                    m_tlast_o,
  input  logic                    m_tready_i,
  input  logic [31:0]             udt_state_i,
  input  logic [2:0]              state_sel_i,
  input  logic                    state_valid_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    timeout_o
);

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("udt_tx_arbiter: unsupported N_REQ/TIMEOUT");
  end

  arb_state_e       state;
  logic [N_REQ-1:0] en;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] pick;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    gidx;
  logic [PW-1:0]    nxt_ptr;
  logic             hs;

  // Enables are registered, so a CONNECT seen together with
  // valid only makes the requester eligible next cycle.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      en <= '0;
    end else if (state_valid_i) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (state_sel_i == 3'(k)) begin
          if (udt_state_i == CONNECT)
            en[k] <= 1'b1;
          else if (udt_state_i == CLOSE)
            en[k] <= 1'b0;
        end
      end
    end
  end

  assign elig = s_tvalid_i & en;

  udt_rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  // grant_o is zero in IDLE, so it alone gates the datapath.
  always_comb begin
    m_tdata_o = '0;
    gidx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_o[k]) begin
        m_tdata_o = s_tdata_i[k*DATA_W +: DATA_W];
        gidx      = PW'(k);
      end
    end
  end

  assign m_tvalid_o = |(grant_o & s_tvalid_i);
  assign m_tlast_o  = |(grant_o & s_tlast_i);
  assign s_tready_o = grant_o & {N_REQ{m_tready_i}};
  assign hs         = m_tvalid_o & m_tready_i;
  assign nxt_ptr    = (gidx == PW'(N_REQ - 1)) ? '0
                                               : gidx + PW'(1);

`ifdef UDT_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] stall;
  logic          stall_hit;

  assign stall_hit = !hs && (stall == CW'(TIMEOUT - 1));

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state     <= ARB_IDLE;
      grant_o   <= '0;
      rr_ptr    <= '0;
      stall     <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          stall <= '0;
          if (|elig) begin
            grant_o <= pick;
            state   <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          if (hs && m_tlast_o) begin
            state   <= ARB_IDLE;
            grant_o <= '0;
            rr_ptr  <= nxt_ptr;
            stall   <= '0;
          end else if (hs) begin
            stall <= '0;
          end else if (stall_hit) begin
            state     <= ARB_IDLE;
            grant_o   <= '0;
            rr_ptr    <= nxt_ptr;
            stall     <= '0;
            timeout_o <= 1'b1;
          end else begin
            stall <= stall + CW'(1);
          end
        end
      endcase
    end
  end
`else
  assign timeout_o = 1'b0;

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state   <= ARB_IDLE;
      grant_o <= '0;
      rr_ptr  <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (|elig) begin
            grant_o <= pick;
            state   <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          if (hs && m_tlast_o) begin
            state   <= ARB_IDLE;
            grant_o <= '0;
            rr_ptr  <= nxt_ptr;
          end
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_udt_tx_arbiter.sv
// Bench for udt_tx_arbiter: directed scenarios plus random
// traffic against a packet-level reference model.
module tb_udt_tx_arbiter;
  import udt_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 1024;

  logic            core_clk = 1'b0;
  logic            core_rst = 1'b1;
  logic [N-1:0]    tv;
  logic [N*DW-1:0] td;
  logic [N-1:0]    tl;
  logic [N-1:0]    srdy;
  logic            mtv;
  logic [DW-1:0]   mtd;
  logic            mtl;
  logic            mtr;
  logic [31:0]     st;
  logic [2:0]      sel;
  logic            sv;
  logic [N-1:0]    gnt;
  logic            to;

  always #5 core_clk = ~core_clk;

  udt_tx_arbiter #(
    .N_REQ   (N),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .core_clk      (core_clk),
    .core_rst      (core_rst),
    .s_tvalid_i    (tv),
    .s_tdata_i     (td),
    .s_tlast_i     (tl),
    .s_tready_o    (srdy),
    .m_tvalid_o    (mtv),
    .m_tdata_o     (mtd),
    .m_tlast_o     (mtl),
    .m_tready_i    (mtr),
    .udt_state_i   (st),
    .state_sel_i   (sel),
    .state_valid_i (sv),
    .grant_o       (gnt),
    .timeout_o     (to)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: who holds the port (-1 = nobody), where the
  // next search starts, socket enables, stall age.
  bit         men[N];
  int         mg;
  int         mptr;
  int         mstall;
  bit         mto;
  int         bc[N];
  int         blen[N];
  int         pk[N];
  bit         fixlen;
  int         gq[$];
  logic [N-1:0] pgnt;
  int         tocnt;

  task automatic mreset();
    for (int k = 0; k < N; k++) begin
      men[k] = 1'b0;
      bc[k]  = 0;
      pk[k]  = 0;
    end
    mg     = -1;
    mptr   = 0;
    mstall = 0;
    mto    = 1'b0;
  endtask

  task automatic cyc(input logic [N-1:0] v, input bit rdy,
                     input bit svi, input logic [2:0] s,
                     input logic [31:0] code);
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    logic          ev;
    logic          el;
    bit            nto;
    bit            last;
    int            j;
    @(negedge core_clk);
    tv  = v;
    mtr = rdy;
    sv  = svi;
    sel = s;
    st  = code;
    for (int k = 0; k < N; k++) begin
      tl[k] = (bc[k] == blen[k] - 1);
      td[k*DW +: DW] = {8'(k), 8'(pk[k]), 16'(bc[k])};
    end
    #1;
    eg = '0;
    ed = '0;
    ev = 1'b0;
    el = 1'b0;
    if (mg >= 0) begin
      eg[mg] = 1'b1;
      ed = td[mg*DW +: DW];
      ev = v[mg];
      el = tl[mg];
    end
    chk("grant", 64'(gnt), 64'(eg));
    chk("m_tvalid", 64'(mtv), 64'(ev));
    if (ev) begin
      chk("m_tdata", 64'(mtd), 64'(ed));
      chk("m_tlast", 64'(mtl), 64'(el));
    end
    chk("s_tready", 64'(srdy), 64'(eg & {N{rdy}}));
    chk("timeout", 64'(to), 64'(mto));
    if (to) tocnt++;
    if (gnt != 0 && pgnt == 0)
      for (int k = 0; k < N; k++)
        if (gnt[k]) gq.push_back(k);
    pgnt = gnt;
    @(posedge core_clk);
    nto = 1'b0;
    if (mg < 0) begin
      for (int i = 0; i < N; i++) begin
        j = (mptr + i) % N;
        if (v[j] && men[j]) begin
          mg = j;
          break;
        end
      end
    end else if (v[mg] && rdy) begin
      last   = (bc[mg] == blen[mg] - 1);
      mstall = 0;
      if (last) begin
        bc[mg] = 0;
        pk[mg]++;
        if (!fixlen) blen[mg] = $urandom_range(1, 4);
        mptr = (mg + 1) % N;
        mg   = -1;
      end else begin
        bc[mg]++;
      end
    end
`ifdef UDT_TX_ARB_TIMEOUT_EN
    else begin
      mstall++;
      if (mstall == TO) begin
        nto    = 1'b1;
        mstall = 0;
        mptr   = (mg + 1) % N;
        mg     = -1;
      end
    end
`endif
    mto = nto;
    if (svi && int'(s) < N) begin
      if (code == UDT_CONNECT) men[s] = 1'b1;
      else if (code == UDT_CLOSE) men[s] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge core_clk);
    core_rst = 1'b1;
    sv = 1'b0;
    #1;
    chk("rst grant", 64'(gnt), 64'(0));
    chk("rst m_tvalid", 64'(mtv), 64'(0));
    chk("rst s_tready", 64'(srdy), 64'(0));
    chk("rst timeout", 64'(to), 64'(0));
    mreset();
    pgnt  = '0;
    tocnt = 0;
    @(negedge core_clk);
    core_rst = 1'b0;
  endtask

  task automatic set_len(input int n);
    for (int k = 0; k < N; k++) blen[k] = n;
  endtask

  logic [31:0] rcode;

  initial begin
    tv = '0; td = '0; tl = '0; mtr = 1'b0;
    sv = 1'b0; sel = '0; st = '0; pgnt = '0;
    fixlen = 1'b1;
    set_len(3);
    mreset();
    do_reset();

    // Two connected requesters, 3-beat packets.
    cyc('0, 1, 1, 3'd0, UDT_CONNECT);
    cyc('0, 1, 1, 3'd2, UDT_CONNECT);
    gq.delete();
    repeat (10) cyc(4'b0101, 1, 0, 3'd0, 32'h0);
    chk("pair first", 64'(gq.size() > 0 ? gq[0] : 99), 64'(0));
    chk("pair second", 64'(gq.size() > 1 ? gq[1] : 99), 64'(2));

    // All connected, 1-beat packets: strict rotation.
    do_reset();
    set_len(1);
    for (int k = 0; k < N; k++)
      cyc('0, 1, 1, 3'(k), UDT_CONNECT);
    gq.delete();
    repeat (12) cyc(4'hf, 1, 0, 3'd0, 32'h0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rotation %0d", i),
          64'(gq.size() > i ? gq[i] : 99), 64'(i % N));

    // Req1 never connected; req0 closed mid-packet.
    do_reset();
    set_len(5);
    cyc('0, 1, 1, 3'd0, UDT_CONNECT);
    gq.delete();
    repeat (3) cyc(4'b0011, 1, 0, 3'd0, 32'h0);
    cyc(4'b0011, 1, 1, 3'd0, UDT_CLOSE);
    repeat (100) cyc(4'b0011, 1, 0, 3'd0, 32'h0);
    chk("close grants", 64'(gq.size()), 64'(1));
    chk("closed pkts", 64'(pk[0]), 64'(1));
    chk("req1 ready", 64'(srdy[1]), 64'(0));

    // Long stall on the shared port.
    do_reset();
    set_len(2);
    cyc('0, 1, 1, 3'd0, UDT_CONNECT);
    repeat (TO + 8) cyc(4'b0001, 0, 0, 3'd0, 32'h0);
`ifdef UDT_TX_ARB_TIMEOUT_EN
    chk("stall pulses", 64'(tocnt), 64'(1));
`else
    chk("stall pulses", 64'(tocnt), 64'(0));
`endif
    chk("stall grant", 64'(gnt), 64'(4'b0001));

    // Reset in the middle of a packet.
    do_reset();
    set_len(5);
    cyc('0, 1, 1, 3'd0, UDT_CONNECT);
    repeat (3) cyc(4'b0001, 1, 0, 3'd0, 32'h0);
    do_reset();
    repeat (4) cyc(4'b0001, 1, 0, 3'd0, 32'h0);
    chk("post rst grant", 64'(gnt), 64'(0));

    // Random traffic and socket churn.
    do_reset();
    fixlen = 1'b0;
    for (int k = 0; k < N; k++) blen[k] = $urandom_range(1, 4);
    repeat (3000) begin
      case ($urandom % 3)
        0:       rcode = UDT_CONNECT;
        1:       rcode = UDT_CLOSE;
        default: rcode = 32'h5;
      endcase
      cyc(4'($urandom), ($urandom % 4) != 0,
          ($urandom % 5) == 0, 3'($urandom), rcode);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
